// File: rtl/sn76489_writer.sv
// Host-side write sequencer for the sn76489 PSG: FIFO-buffered register commands serialised into latch/data bytes.
// Optional macro SN76489_WRITER_DEDUP_EN drops commands that would rewrite a register with its current value.
module sn76489_writer #(
  parameter int FIFO_AW = 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               clk_en,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [2:0]         cmd_reg,
  input  logic [9:0]         cmd_data,
  output logic               busy,
  output logic [FIFO_AW:0]   fifo_count,
  output logic [0:7]         psg_d,
  output logic               psg_we_n,
  output logic               psg_ce_n,
  input  logic               psg_ready
);

  localparam int DEPTH = 1 << FIFO_AW;
  localparam logic [FIFO_AW:0] FULL = (FIFO_AW + 1)'(DEPTH);

  typedef enum logic [2:0] {S_IDLE, S_LATCH, S_GAP1, S_DATA, S_GAP2} state_t;

  typedef struct packed {
    logic [2:0] addr;
    logic [9:0] data;
  } cmd_t;

  state_t             r_state, w_next;
  cmd_t               r_mem [DEPTH];
  logic [FIFO_AW-1:0] r_wr_ptr, r_rd_ptr;
  logic [FIFO_AW:0]   r_count;
  logic [0:7]         r_psg_d;
  logic [7:0]         r_data_byte;
  logic               r_tone;
  logic               r_we_n;

  cmd_t               w_head;
  logic               w_push, w_pop, w_emit, w_dup, w_head_tone, w_strobe_next;
  logic [7:0]         w_latch_byte, w_data_byte;

  assign cmd_ready  = (r_count != FULL);
  assign w_push     = cmd_valid & cmd_ready;
  assign w_head     = r_mem[r_rd_ptr];
  assign w_pop      = (r_state == S_IDLE) && (r_count != '0);
  assign w_emit     = w_pop & ~w_dup;
  assign fifo_count = r_count;
  assign busy       = (r_state != S_IDLE) || (r_count != '0);
  assign psg_d      = r_psg_d;
  assign psg_we_n   = r_we_n;
  assign psg_ce_n   = r_we_n;

  // Tone registers (0/2/4) carry a second data byte with the upper six bits.
  assign w_head_tone = ~w_head.addr[0] && (w_head.addr != 3'd6);

  always_comb begin
    w_latch_byte = {1'b1, w_head.addr, w_head.data[3:0]};
    if (w_head.addr == 3'd6) w_latch_byte[3] = 1'b0;
    w_data_byte = {2'b00, w_head.data[9:4]};
  end

`ifdef SN76489_WRITER_DEDUP_EN
  logic [9:0] r_shadow [8];
  logic [7:0] r_shadow_vld;

  // Noise control is always re-emitted since each write restarts the LFSR.
  assign w_dup = r_shadow_vld[w_head.addr] && (r_shadow[w_head.addr] == w_head.data)
                 && (w_head.addr != 3'd6);

  always_ff @(posedge clk) begin
    if (reset)       r_shadow_vld <= '0;
    else if (w_emit) r_shadow_vld[w_head.addr] <= 1'b1;
  end

  always_ff @(posedge clk) begin
    if (w_emit) r_shadow[w_head.addr] <= w_head.data;
  end
`else
  assign w_dup = 1'b0;
`endif

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:  if (w_emit)               w_next = S_LATCH;
      S_LATCH: if (clk_en && psg_ready) w_next = r_tone ? S_GAP1 : S_GAP2;
      S_GAP1:  if (clk_en)               w_next = S_DATA;
      S_DATA:  if (clk_en && psg_ready) w_next = S_GAP2;
      S_GAP2:  if (clk_en)               w_next = S_IDLE;
      default:                           w_next = S_IDLE;
    endcase
    w_strobe_next = (w_next == S_LATCH) || (w_next == S_DATA);
  end

  // NOTE: FIFO storage has no reset; the pointers alone define which entries are live.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= '{addr: cmd_reg, data: cmd_data};
  end

  // NOTE: all sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_we_n      <= 1'b1;
      r_psg_d     <= '0;
      r_data_byte <= '0;
      r_tone      <= 1'b0;
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
    end else begin
      r_state <= w_next;
      r_we_n  <= ~w_strobe_next;
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
      if (w_emit) begin
        r_psg_d     <= w_latch_byte;
        r_data_byte <= w_data_byte;
        r_tone      <= w_head_tone;
      end else if (r_state == S_GAP1 && w_next == S_DATA) begin
        r_psg_d <= r_data_byte;
      end
    end
  end

endmodule

// File: tb/tb_sn76489_writer.sv
// Directed self-checking bench for sn76489_writer; outputs are sampled 1 time unit after each rising edge.
// Dedup expectations follow SN76489_WRITER_DEDUP_EN when it is defined for the build.
module tb_sn76489_writer;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       clk_en = 1'b1;
  logic       cmd_valid = 1'b0;
  logic [2:0] cmd_reg = '0;
  logic [9:0] cmd_data = '0;
  logic       psg_ready = 1'b1;
  logic       cmd_ready, busy, psg_we_n, psg_ce_n;
  logic [2:0] fifo_count;
  logic [0:7] psg_d;

  int n_cmp = 0;
  int n_fail = 0;
  int n_strobes = 0;
  logic prev_we_n = 1'b1;

  sn76489_writer #(.FIFO_AW(2)) dut (
    .clk(clk), .reset(reset), .clk_en(clk_en),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_reg(cmd_reg), .cmd_data(cmd_data),
    .busy(busy), .fifo_count(fifo_count),
    .psg_d(psg_d), .psg_we_n(psg_we_n), .psg_ce_n(psg_ce_n), .psg_ready(psg_ready)
  );

  always #5 clk = ~clk;

  // Counts strobe assertions (high-to-low transitions) seen mid-cycle.
  always @(negedge clk) begin
    if (prev_we_n && !psg_we_n) n_strobes++;
    prev_we_n = psg_we_n;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [2:0] r, input logic [9:0] d);
    cmd_valid = 1'b1;
    cmd_reg   = r;
    cmd_data  = d;
    tick();
    cmd_valid = 1'b0;
  endtask

  logic [2:0] bp_reg  [5] = '{3'd1, 3'd0, 3'd3, 3'd5, 3'd7};
  logic [9:0] bp_data [5] = '{10'h00F, 10'h123, 10'h001, 10'h002, 10'h00A};

  initial begin
    int n_low;
    int n_low_en;
    int exp_strobes;

    // Reset state
    tick();
    tick();
    check("rst_we_n", psg_we_n, 1);
    check("rst_ce_n", psg_ce_n, 1);
    check("rst_d", psg_d, 0);
    check("rst_ready", cmd_ready, 1);
    check("rst_busy", busy, 0);
    check("rst_count", fifo_count, 0);
    reset = 1'b0;
    tick();

    // Tone: reg 0 = 0x3FE -> latch 0x8E, data 0x3F
    push(3'd0, 10'h3FE);
    check("tone_count1", fifo_count, 1);
    check("tone_busy1", busy, 1);
    check("tone_idle_we", psg_we_n, 1);
    tick();
    check("tone_latch_we", psg_we_n, 0);
    check("tone_latch_ce", psg_ce_n, 0);
    check("tone_latch_d", psg_d, 8'h8E);
    check("tone_count0", fifo_count, 0);
    tick();
    check("tone_gap1_we", psg_we_n, 1);
    check("tone_gap1_d", psg_d, 8'h8E);
    tick();
    check("tone_data_we", psg_we_n, 0);
    check("tone_data_d", psg_d, 8'h3F);
    tick();
    check("tone_gap2_we", psg_we_n, 1);
    check("tone_gap2_busy", busy, 1);
    tick();
    check("tone_idle_busy", busy, 0);
    check("tone_idle_d", psg_d, 8'h3F);

    // Attenuation: reg 3 = 5 -> single byte 0xB5
    push(3'd3, 10'h005);
    tick();
    check("att_we", psg_we_n, 0);
    check("att_d", psg_d, 8'hB5);
    tick();
    check("att_gap2_we", psg_we_n, 1);
    check("att_gap2_busy", busy, 1);
    tick();
    check("att_idle_busy", busy, 0);

    // Pacing: clk_en every 16th cycle, reg 4 = 0x2A5 -> 0xC5 then 0x2A
    clk_en = 1'b0;
    push(3'd4, 10'h2A5);
    tick();
    n_low = 0;
    n_low_en = 0;
    for (int cyc = 0; cyc < 72; cyc++) begin
      clk_en = (cyc % 16 == 15);
      if (!psg_we_n) begin
        n_low++;
        check("pace_d", psg_d, (n_low_en == 0) ? 32'hC5 : 32'h2A);
        if (clk_en) n_low_en++;
      end
      tick();
    end
    check("pace_en_low_cycles", n_low_en, 2);
    check("pace_low_cycles", n_low, 32);
    check("pace_busy", busy, 0);

    // Backpressure: hold first command in LATCH, then offer five more
    clk_en = 1'b0;
    psg_ready = 1'b0;
    push(3'd2, 10'h155);
    tick();
    check("bp_latch_we", psg_we_n, 0);
    check("bp_latch_d", psg_d, 8'hA5);
    for (int i = 0; i < 5; i++) begin
      cmd_valid = 1'b1;
      cmd_reg   = bp_reg[i];
      cmd_data  = bp_data[i];
      check("bp_ready", cmd_ready, (i < 4) ? 1 : 0);
      tick();
    end
    cmd_valid = 1'b0;
    check("bp_count_full", fifo_count, 4);
    check("bp_ready_full", cmd_ready, 0);
    clk_en = 1'b1;
    repeat (3) begin
      tick();
      check("bp_hold_not_ready", psg_we_n, 0);
    end
    psg_ready = 1'b1;
    clk_en = 1'b0;
    tick();
    check("bp_hold_no_en", psg_we_n, 0);
    clk_en = 1'b1;
    tick();
    check("bp_gap1_we", psg_we_n, 1);
    tick();
    check("bp_data_d", psg_d, 8'h15);
    tick();
    tick();
    check("bp_idle_count", fifo_count, 4);
    tick();
    check("bp_b_d", psg_d, 8'h9F);
    check("bp_b_count", fifo_count, 3);
    tick();
    tick();
    tick();
    check("bp_c_d", psg_d, 8'h83);
    check("bp_c_we", psg_we_n, 0);
    tick();
    check("bp_c_gap1_we", psg_we_n, 1);
    check("bp_c_gap1_count", fifo_count, 2);

    // Reset mid-tone (in GAP1, two queued)
    reset = 1'b1;
    tick();
    check("mid_rst_we", psg_we_n, 1);
    check("mid_rst_ce", psg_ce_n, 1);
    check("mid_rst_count", fifo_count, 0);
    check("mid_rst_ready", cmd_ready, 1);
    check("mid_rst_busy", busy, 0);
    reset = 1'b0;
    n_strobes = 0;
    repeat (10) tick();
    check("mid_rst_no_strobe", n_strobes, 0);

    // Dedup: reg 1 = 7 twice, reg 6 = 3 twice
`ifdef SN76489_WRITER_DEDUP_EN
    exp_strobes = 3;
`else
    exp_strobes = 4;
`endif
    n_strobes = 0;
    push(3'd1, 10'h007);
    push(3'd1, 10'h007);
    push(3'd6, 10'h003);
    push(3'd6, 10'h003);
    repeat (20) tick();
    check("dedup_strobes", n_strobes, exp_strobes);
    check("dedup_busy", busy, 0);
    check("dedup_last_d", psg_d, 8'hE3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
